// File: rtl/cram_pkg.sv
// ============================================================================
// Module      : cram_pkg
// Description : Shared CRAM write-path widths and the write-entry record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cram_pkg;

    localparam int CRAM_AW = 8;
    localparam int CRAM_DW = 15;

    typedef struct packed {
        logic [CRAM_AW-1:0] addr;
        logic [CRAM_DW-1:0] data;
    } cram_wr_t;

endpackage

`default_nettype wire

// File: rtl/cram_wr_fifo.sv
// ============================================================================
// Module      : cram_wr_fifo
// Description : Synchronous FIFO of CRAM write entries, two push ports
//               (A lands ahead of B) and one pop port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cram_wr_fifo
    import cram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_a,
    input  cram_wr_t      din_a,
    input  logic          push_b,
    input  cram_wr_t      din_b,
    input  logic          pop,
    output cram_wr_t      dout,
    output logic [CW-1:0] count
);

    cram_wr_t      r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_b_ptr;
    logic          w_pop;

    // Port B takes the slot after port A only when A is also pushing.
    assign w_b_ptr = push_a ? r_wr_ptr + PW'(1) : r_wr_ptr;
    assign w_pop   = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (push_a)
            r_mem[r_wr_ptr] <= din_a;
        if (push_b)
            r_mem[w_b_ptr] <= din_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(push_a) + PW'(push_b);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(push_a) + CW'(push_b) - CW'(w_pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cram_writer.sv
// ============================================================================
// Module      : cram_writer
// Description : CRAM write front end: CPU byte assembly, DMA word writes,
//               ordered merge FIFO and registered CRAM write port.
//               Optional readback shadow RAM under CRAM_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cram_writer
    import cram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_wr_stb,
    input  logic [8:0]          cpu_addr,
    input  logic [7:0]          cpu_wdata,
    input  logic                dma_req,
    input  logic [CRAM_AW-1:0]  dma_addr,
    input  logic [15:0]         dma_data,
    output logic                dma_rdy,
    output logic [CRAM_AW-1:0]  cram_addr,
    output logic [CRAM_DW-1:0]  cram_data,
    output logic                cram_we,
    output logic                busy,
    input  logic [8:0]          cpu_rd_addr,
    output logic [7:0]          cpu_rdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    r_lo_latch;
    logic          w_cpu_commit;
    logic          w_dma_acc;
    cram_wr_t      w_cpu_entry;
    cram_wr_t      w_dma_entry;
    cram_wr_t      w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_pop;

    assign w_cpu_commit = cpu_wr_stb && cpu_addr[0];
    assign w_dma_acc    = dma_req && dma_rdy;
    assign w_cpu_entry  = '{addr: cpu_addr[8:1], data: {cpu_wdata[6:0], r_lo_latch}};
    assign w_dma_entry  = '{addr: dma_addr, data: dma_data[14:0]};
    assign w_pop        = (w_count != '0);
    assign w_count_next = w_count + CW'(w_cpu_commit) + CW'(w_dma_acc) - CW'(w_pop);

    cram_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (w_cpu_commit),
        .din_a  (w_cpu_entry),
        .push_b (w_dma_acc),
        .din_b  (w_dma_entry),
        .pop    (w_pop),
        .dout   (w_head),
        .count  (w_count)
    );

    // DMA is throttled one slot early so a CPU commit always has room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo_latch <= '0;
            dma_rdy    <= 1'b1;
            cram_we    <= 1'b0;
            cram_addr  <= '0;
            cram_data  <= '0;
        end else begin
            if (cpu_wr_stb && !cpu_addr[0])
                r_lo_latch <= cpu_wdata;
            dma_rdy <= (w_count_next <= CW'(FIFO_DEPTH - 2));
            cram_we <= w_pop;
            if (w_pop) begin
                cram_addr <= w_head.addr;
                cram_data <= w_head.data;
            end
        end
    end

    assign busy = w_pop || cram_we;

`ifdef CRAM_READBACK_EN
    logic [CRAM_DW-1:0] r_shadow [256];
    logic [CRAM_DW-1:0] w_rd_word;
    logic               unused_bits;

    always_ff @(posedge clk) begin
        if (cram_we)
            r_shadow[cram_addr] <= cram_data;
    end

    assign w_rd_word = r_shadow[cpu_rd_addr[8:1]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cpu_rdata <= '0;
        else
            cpu_rdata <= cpu_rd_addr[0] ? {1'b0, w_rd_word[14:8]} : w_rd_word[7:0];
    end

    assign unused_bits = ^{dma_data[15], cpu_wdata[7]};
`else
    logic unused_bits;

    assign cpu_rdata   = '0;
    assign unused_bits = ^{dma_data[15], cpu_wdata[7], cpu_rd_addr};
`endif

endmodule

`default_nettype wire

// File: tb/tb_cram_writer.sv
// ============================================================================
// Module      : tb_cram_writer
// Description : Randomised self-checking bench for cram_writer against a
//               write-schedule scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cram_writer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_stb;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    logic [7:0]  dma_addr;
    logic [15:0] dma_data;
    logic        dma_rdy;
    logic [7:0]  cram_addr;
    logic [14:0] cram_data;
    logic        cram_we;
    logic        busy;
    logic [8:0]  cpu_rd_addr;
    logic [7:0]  cpu_rdata;

    cram_writer #(.FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wr_stb  (cpu_wr_stb),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_rdy     (dma_rdy),
        .cram_addr   (cram_addr),
        .cram_data   (cram_data),
        .cram_we     (cram_we),
        .busy        (busy),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_rdata   (cpu_rdata)
    );

    always #5 clk = ~clk;

    // Each expected write carries the cycle in which cram_we must show it.
    typedef struct {
        logic [7:0]  addr;
        logic [14:0] data;
        int          wcyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc;
    int          last_w;
    int          n_cmp;
    int          n_bad;
    int          we_seen;
    logic [7:0]  lo;
    logic [14:0] shadow [256];
    bit          shadow_ok [256];
    bit          pend_wr;
    logic [7:0]  pend_addr;
    logic [14:0] pend_data;
    logic [7:0]  exp_rdata;
    bit          exp_rdata_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic enqueue(input logic [7:0] a, input logic [14:0] d);
        int w;
        w = (cyc + 2 > last_w + 1) ? cyc + 2 : last_w + 1;
        last_w = w;
        exp_q.push_back('{addr: a, data: d, wcyc: w});
    endtask

    function automatic logic [7:0] rb_byte(input logic [8:0] ra);
        logic [14:0] w;
        w = shadow[ra[8:1]];
        return ra[0] ? {1'b0, w[14:8]} : w[7:0];
    endfunction

    // One clock: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input logic stb, input logic [8:0] a, input logic [7:0] wd,
                        input logic req, input logic [7:0] da, input logic [15:0] dd,
                        input logic [8:0] ra, output bit acc);
        bit have_wr;
        bit rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (pend_wr) begin
            shadow[pend_addr]    = pend_data;
            shadow_ok[pend_addr] = 1'b1;
            pend_wr = 1'b0;
        end
        have_wr = (exp_q.size() > 0) && (exp_q[0].wcyc == cyc);
        check("cram_we", cram_we, have_wr);
        if (cram_we) we_seen++;
        if (have_wr) begin
            check("cram_addr", cram_addr, exp_q[0].addr);
            check("cram_data", cram_data, exp_q[0].data);
            pend_wr   = 1'b1;
            pend_addr = exp_q[0].addr;
            pend_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        rdy = (exp_q.size() <= D - 2);
        check("dma_rdy", dma_rdy, rdy);
        check("busy", busy, (exp_q.size() > 0) || have_wr);
`ifdef CRAM_READBACK_EN
        if (exp_rdata_ok) check("cpu_rdata", cpu_rdata, exp_rdata);
`else
        check("cpu_rdata", cpu_rdata, 8'h00);
`endif
        cpu_wr_stb  = stb;
        cpu_addr    = a;
        cpu_wdata   = wd;
        dma_req     = req;
        dma_addr    = da;
        dma_data    = dd;
        cpu_rd_addr = ra;
        acc = req && rdy;
        if (stb) begin
            if (!a[0]) lo = wd;
            else enqueue(a[8:1], {wd[6:0], lo});
        end
        if (acc) enqueue(da, dd[14:0]);
        exp_rdata_ok = shadow_ok[ra[8:1]];
        exp_rdata    = rb_byte(ra);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            step(1'b0, 9'h0, 8'h0, 1'b0, 8'h0, 16'h0, 9'h0, acc);
    endtask

    initial begin
        bit          acc;
        bit          req_on;
        logic [7:0]  rq_a;
        logic [15:0] rq_d;
        int          idx;
        int          base;

        rst = 1'b1;
        cpu_wr_stb = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_addr = 0; dma_data = 0; cpu_rd_addr = 0;
        cyc = 0; last_w = 0; n_cmp = 0; n_bad = 0; we_seen = 0; lo = 8'h00;
        pend_wr = 0; exp_rdata = 8'h00; exp_rdata_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            shadow[i] = '0;
            shadow_ok[i] = 1'b0;
        end

        #12;
        check("rst_we", cram_we, 1'b0);
        check("rst_addr", cram_addr, 8'h00);
        check("rst_data", cram_data, 15'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", dma_rdy, 1'b1);
        check("rst_rdata", cpu_rdata, 8'h00);
        rst = 1'b0;

        // Basic CPU byte pair
        idle(2);
        step(1'b1, {8'h05, 1'b0}, 8'h1F, 1'b0, 8'h0, 16'h0, 9'h0, acc);
        step(1'b1, {8'h05, 1'b1}, 8'h7C, 1'b0, 8'h0, 16'h0, 9'h0, acc);
        idle(1);
        check("basic_we_early", cram_we, 1'b0);
        idle(1);
        check("basic_we", cram_we, 1'b1);
        check("basic_addr", cram_addr, 8'h05);
        check("basic_data", cram_data, 15'h7C1F);
        idle(1);
        check("basic_one_pulse", cram_we, 1'b0);

        // DMA burst, 8 words
        idle(2);
        base = we_seen;
        idx = 0;
        for (int k = 0; k < 40 && idx < 8; k++) begin
            step(1'b0, 9'h0, 8'h0, 1'b1, 8'h10 + 8'(idx), 16'($urandom), 9'h0, acc);
            check("burst_rdy", dma_rdy, 1'b1);
            if (acc) idx++;
        end
        check("burst_accepted", idx, 8);
        idle(4);
        check("burst_pulses", we_seen - base, 8);

        // Same-cycle CPU commit and DMA accept
        step(1'b1, {8'h01, 1'b1}, 8'h33, 1'b1, 8'h02, 16'h5555, 9'h0, acc);
        check("coll_acc", acc, 1'b1);
        idle(2);
        check("coll_first", cram_addr, 8'h01);
        idle(1);
        check("coll_second", cram_addr, 8'h02);
        check("coll_second_we", cram_we, 1'b1);
        idle(2);

        // Asynchronous reset with three entries queued
        step(1'b1, {8'h30, 1'b1}, 8'h11, 1'b1, 8'h31, 16'h1234, 9'h0, acc);
        step(1'b1, {8'h32, 1'b1}, 8'h22, 1'b1, 8'h33, 16'h4321, 9'h0, acc);
        step(1'b0, 9'h0, 8'h0, 1'b0, 8'h0, 16'h0, 9'h0, acc);
        #2 rst = 1'b1;
        #1;
        check("arst_we", cram_we, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rdy", dma_rdy, 1'b1);
        check("arst_addr", cram_addr, 8'h00);
        #1 rst = 1'b0;
        exp_q.delete();
        last_w = 0;
        lo = 8'h00;
        pend_wr = 1'b0;
        exp_rdata_ok = shadow_ok[cpu_rd_addr[8:1]];
        exp_rdata = rb_byte(cpu_rd_addr);
        base = we_seen;
        idle(6);
        check("arst_no_stale", we_seen - base, 0);

`ifdef CRAM_READBACK_EN
        step(1'b0, 9'h0, 8'h0, 1'b1, 8'hFF, 16'h4210, 9'h0, acc);
        check("rb_acc", acc, 1'b1);
        idle(4);
        step(1'b0, 9'h0, 8'h0, 1'b0, 8'h0, 16'h0, 9'h1FE, acc);
        step(1'b0, 9'h0, 8'h0, 1'b0, 8'h0, 16'h0, 9'h1FF, acc);
        check("rb_lo", cpu_rdata, 8'h10);
        idle(1);
        check("rb_hi", cpu_rdata, 8'h42);
`endif

        // Random mixed traffic with held DMA requests
        req_on = 1'b0;
        rq_a = '0;
        rq_d = '0;
        for (int k = 0; k < 2000; k++) begin
            if (!req_on && ($urandom_range(0, 1) == 1)) begin
                req_on = 1'b1;
                rq_a = 8'($urandom);
                rq_d = 16'($urandom);
            end
            step($urandom_range(0, 2) == 0, 9'($urandom), 8'($urandom),
                 req_on, rq_a, rq_d, 9'($urandom), acc);
            if (acc) req_on = 1'b0;
        end
        idle(10);
        check("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cram_writer.md
# cram_writer

Write-side front end for the 256-entry × 15-bit colour RAM (CRAM) that the video output stage reads as its palette. It assembles CPU byte writes into 15-bit palette words and accepts whole-word DMA writes. It merges both sources in order through a small FIFO and drives the CRAM write port (`cram_addr`, `cram_data`, `cram_we`) with at most one registered write per clock. It sits between the CPU/DMA bus decode and the CRAM write port of the video output block.

## Interface
- `FIFO_DEPTH`, 4, merge FIFO entries; power of two, ≥ 2
- `clk  in  1`  system clock, all logic on rising edge
- `rst  in  1`  reset, asynchronous, active-high
- `cpu_wr_stb  in  1`  one-cycle CPU write strobe to the CRAM window
- `cpu_addr  in  9`  byte address: [8:1] = palette entry, [0] = 0 low byte / 1 high byte
- `cpu_wdata  in  8`  CPU write byte
- `dma_req  in  1`  DMA word write request; held until accepted
- `dma_addr  in  8`  DMA palette entry
- `dma_data  in  16`  DMA word; bit 15 ignored
- `dma_rdy  out  1`  DMA accepted on cycles where `dma_req && dma_rdy`
- `cram_addr  out  8`  CRAM write address
- `cram_data  out  15`  CRAM write data, {R[4:0], G[4:0], B[4:0]}
- `cram_we  out  1`  CRAM write enable, one cycle per word
- `busy  out  1`  FIFO non-empty or `cram_we` high
- `cpu_rd_addr  in  9`  readback byte address (used only with the readback feature)
- `cpu_rdata  out  8`  readback byte

## Operation
- Low-byte CPU write (`cpu_addr[0]`=0): stores `cpu_wdata` in `lo_latch`. Nothing is enqueued.
- High-byte CPU write: enqueues {addr=`cpu_addr[8:1]`, data={`cpu_wdata[6:0]`, `lo_latch`}}.
  - `cpu_wdata[7]` is ignored.
  - The entry field of the low write is not checked: the high write always uses whatever `lo_latch` holds.
  - `lo_latch` keeps its value after the commit.
- DMA: on `dma_req && dma_rdy`, enqueues {`dma_addr`, `dma_data[14:0]`}.
- Same-cycle CPU commit and DMA accept: both are enqueued, CPU entry first.
- `dma_rdy` is registered. It is 1 when the count after this cycle's update is ≤ FIFO_DEPTH−2, so one slot is always held for the CPU. The CPU cannot stall and can never overflow the FIFO.
- Drain: whenever the FIFO is non-empty, pop one entry per cycle into the output registers and assert `cram_we` for one cycle. Writes are never held back.
- Pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1 bits.
- Reset (at any time, including mid-burst):
  - FIFO is emptied; pending entries are discarded.
  - Outputs: `cram_we`=0, `cram_addr`=0, `cram_data`=0, `busy`=0, `dma_rdy`=1, `cpu_rdata`=0.
  - `lo_latch`=0.

## Timing
- CPU high write with strobe in cycle N and FIFO empty: `cram_we` is high during cycle N+2 (enqueue at end of N, output registers loaded at end of N+1).
- DMA accept in cycle N: same latency, `cram_we` during N+2.
- Throughput: 1 word per cycle sustained.
- Back-to-back CPU commits on consecutive cycles produce `cram_we` on consecutive cycles.
- `dma_rdy` deasserts no later than the cycle after the count reaches FIFO_DEPTH−1.

## Configuration
- `CRAM_READBACK_EN` defined:
  - A 256×15 shadow RAM is updated on every `cram_we` with `cram_addr`/`cram_data`.
  - `cpu_rdata` is registered with 1-cycle latency: low byte = data[7:0], high byte = {1'b0, data[14:8]}.
  - A read and a write to the same entry in the same cycle returns the old data.
- Undefined: no shadow RAM; `cpu_rdata` is constant 0 and `cpu_rd_addr` is unused.

## Structure
- Shared package `cram_pkg`:
  - `CRAM_AW`=8, `CRAM_DW`=15
  - struct `cram_wr_t` {addr, data}
- One sub-module, `cram_wr_fifo`:
  - synchronous FIFO of `cram_wr_t`, FIFO_DEPTH entries
  - dual push port (A before B), single pop
  - provides count output
- Byte assembly, arbitration, output registers and the readback shadow RAM live in `cram_writer`.

## Test plan
- Basic CPU write: low write 0x1F to entry 0x05, then high write 0x7C, after reset → `cram_we` for one cycle two cycles after the high strobe, with `cram_addr`=0x05 and `cram_data`=0x7C1F.
- DMA burst: `dma_req` held with 8 words to entries 0x10–0x17, no CPU traffic → 8 consecutive `cram_we` pulses in order; `dma_rdy` never low.
- Collision: CPU high write to entry 0x01 and DMA write to entry 0x02 in the same cycle → `cram_we` to 0x01 in cycle N+2, then to 0x02 in cycle N+3.
- Reset mid-operation: FIFO holding 3 entries, `rst` pulsed asynchronously → `cram_we`=0 immediately, no stale writes afterwards, `dma_rdy`=1, `busy`=0.
- Readback with `CRAM_READBACK_EN`: write 0x4210 to entry 0xFF, then read byte addresses 0x1FE and 0x1FF → 0x10 and 0x42 respectively, one cycle after each read address is presented.
